// File: rtl/vga_sprite_mover_if.sv
// Signal bundle between the sprite mover and the tick source / pixel generator.
// The master side is the sprite mover itself, which drives the position outputs.
interface vga_sprite_mover_if;
    logic       tick_in;
    logic       run;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic       dir_x;
    logic       dir_y;
    logic       move_strobe;
    logic       bounce;
    logic       corner;

    modport master (
        input  tick_in, run,
        output x_pos, y_pos, dir_x, dir_y, move_strobe, bounce, corner
    );

    modport slave (
        output tick_in, run,
        input  x_pos, y_pos, dir_x, dir_y, move_strobe, bounce, corner
    );
endinterface

// File: rtl/vga_sprite_mover.sv
// Bouncing-sprite position generator: one motion step per rising edge of the
// divided tick, which is synchronised and edge-detected as ordinary data.
module vga_sprite_mover #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_W    = 16,
    parameter int BOX_H    = 16,
    parameter int STEP     = 1,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0
) (
    input logic                clk_in,
    input logic                rst,
    vga_sprite_mover_if.master bus
);

    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - BOX_W);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - BOX_H);
    localparam logic [10:0] STEP_W = 11'(STEP);

    typedef enum logic [1:0] {DR, DL, UR, UL} state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q, d_q;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        strobe_q, strobe_d;
    logic        bounce_q, bounce_d;
    logic        corner_q, corner_d;

    logic        step_evt, right, down;
    logic        flip_x, flip_y, right_nxt, down_nxt;
    logic [10:0] x_ext, y_ext, x_inc, x_dec, y_inc, y_dec;
    logic [9:0]  x_nxt;
    logic [8:0]  y_nxt;
    state_t      state_nxt;

    assign right    = (state_q == DR) || (state_q == UR);
    assign down     = (state_q == DR) || (state_q == DL);
    assign step_evt = s2_q & ~d_q & bus.run;

    // Eleven-bit arithmetic keeps the edge comparisons free of wrap-around.
    assign x_ext = {1'b0, x_q};
    assign y_ext = {2'b00, y_q};
    assign x_inc = x_ext + STEP_W;
    assign x_dec = x_ext - STEP_W;
    assign y_inc = y_ext + STEP_W;
    assign y_dec = y_ext - STEP_W;

    always_comb begin
        flip_x = 1'b0;
        flip_y = 1'b0;
        x_nxt  = 10'(x_dec);
        y_nxt  = 9'(y_dec);

        if (right) begin
            if (x_inc >= XMAX) begin
                x_nxt  = 10'(XMAX);
                flip_x = 1'b1;
            end else begin
                x_nxt = 10'(x_inc);
            end
        end else if (x_ext <= STEP_W) begin
            x_nxt  = '0;
            flip_x = 1'b1;
        end

        if (down) begin
            if (y_inc >= YMAX) begin
                y_nxt  = 9'(YMAX);
                flip_y = 1'b1;
            end else begin
                y_nxt = 9'(y_inc);
            end
        end else if (y_ext <= STEP_W) begin
            y_nxt  = '0;
            flip_y = 1'b1;
        end

        right_nxt = right ^ flip_x;
        down_nxt  = down ^ flip_y;
        case ({down_nxt, right_nxt})
            2'b11:   state_nxt = DR;
            2'b10:   state_nxt = DL;
            2'b01:   state_nxt = UR;
            default: state_nxt = UL;
        endcase

        x_d      = step_evt ? x_nxt : x_q;
        y_d      = step_evt ? y_nxt : y_q;
        state_d  = step_evt ? state_nxt : state_q;
        strobe_d = step_evt;
        bounce_d = step_evt & (flip_x | flip_y);
        corner_d = step_evt & flip_x & flip_y;
    end

    // Sync flops reset high so a tick already high at reset is not seen as an edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            d_q      <= 1'b1;
            x_q      <= 10'(X_INIT);
            y_q      <= 9'(Y_INIT);
            state_q  <= DR;
            strobe_q <= 1'b0;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
        end else begin
            s1_q     <= bus.tick_in;
            s2_q     <= s1_q;
            d_q      <= s2_q;
            x_q      <= x_d;
            y_q      <= y_d;
            state_q  <= state_d;
            strobe_q <= strobe_d;
            bounce_q <= bounce_d;
            corner_q <= corner_d;
        end
    end

    assign bus.x_pos       = x_q;
    assign bus.y_pos       = y_q;
    assign bus.dir_x       = right;
    assign bus.dir_y       = down;
    assign bus.move_strobe = strobe_q;
    assign bus.bounce      = bounce_q;
    assign bus.corner      = corner_q;

endmodule

// File: tb/tb_vga_sprite_mover.sv
// Bench for vga_sprite_mover: four differently parameterised instances share one
// stimulus stream and are compared every cycle against a sample-log reference model.
module tb_vga_sprite_mover;

    localparam int XMAX   = 640 - 16;
    localparam int YMAX   = 480 - 16;
    localparam int HIST_N = 40000;

    localparam int A_X0 = 0,   A_Y0 = 0,   A_ST = 1;
    localparam int B_X0 = 622, B_Y0 = 100, B_ST = 1;
    localparam int C_X0 = 623, C_Y0 = 463, C_ST = 1;
    localparam int D_X0 = 609, D_Y0 = 464, D_ST = 15;

    logic clk_in = 1'b0;
    logic rst, tick, run;

    always #10 clk_in = ~clk_in;

    vga_sprite_mover_if if_a ();
    vga_sprite_mover_if if_b ();
    vga_sprite_mover_if if_c ();
    vga_sprite_mover_if if_d ();

    assign if_a.tick_in = tick;
    assign if_b.tick_in = tick;
    assign if_c.tick_in = tick;
    assign if_d.tick_in = tick;
    assign if_a.run = run;
    assign if_b.run = run;
    assign if_c.run = run;
    assign if_d.run = run;

    vga_sprite_mover #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_W(16), .BOX_H(16),
                       .STEP(A_ST), .X_INIT(A_X0), .Y_INIT(A_Y0))
        dut_a (.clk_in(clk_in), .rst(rst), .bus(if_a));
    vga_sprite_mover #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_W(16), .BOX_H(16),
                       .STEP(B_ST), .X_INIT(B_X0), .Y_INIT(B_Y0))
        dut_b (.clk_in(clk_in), .rst(rst), .bus(if_b));
    vga_sprite_mover #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_W(16), .BOX_H(16),
                       .STEP(C_ST), .X_INIT(C_X0), .Y_INIT(C_Y0))
        dut_c (.clk_in(clk_in), .rst(rst), .bus(if_c));
    vga_sprite_mover #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_W(16), .BOX_H(16),
                       .STEP(D_ST), .X_INIT(D_X0), .Y_INIT(D_Y0))
        dut_d (.clk_in(clk_in), .rst(rst), .bus(if_d));

    logic [9:0] act_x  [4];
    logic [8:0] act_y  [4];
    logic       act_dx [4];
    logic       act_dy [4];
    logic       act_mv [4];
    logic       act_bo [4];
    logic       act_co [4];

    assign act_x  = '{if_a.x_pos, if_b.x_pos, if_c.x_pos, if_d.x_pos};
    assign act_y  = '{if_a.y_pos, if_b.y_pos, if_c.y_pos, if_d.y_pos};
    assign act_dx = '{if_a.dir_x, if_b.dir_x, if_c.dir_x, if_d.dir_x};
    assign act_dy = '{if_a.dir_y, if_b.dir_y, if_c.dir_y, if_d.dir_y};
    assign act_mv = '{if_a.move_strobe, if_b.move_strobe, if_c.move_strobe, if_d.move_strobe};
    assign act_bo = '{if_a.bounce, if_b.bounce, if_c.bounce, if_d.bounce};
    assign act_co = '{if_a.corner, if_b.corner, if_c.corner, if_d.corner};

    int    p_x0 [4] = '{A_X0, B_X0, C_X0, D_X0};
    int    p_y0 [4] = '{A_Y0, B_Y0, C_Y0, D_Y0};
    int    p_st [4] = '{A_ST, B_ST, C_ST, D_ST};
    string nm   [4] = '{"A", "B", "C", "D"};

    int m_x [4], m_y [4], m_dx [4], m_dy [4];
    bit m_mv [4], m_bo [4], m_co [4];

    bit hist [HIST_N];
    int cyc         = 3;
    bit model_valid = 1'b0;
    int passed      = 0;
    int total       = 0;
    int strobes_a   = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic applyStimulus(input bit t, input bit r, input bit rs, input int n);
        tick = t;
        run  = r;
        rst  = rs;
        repeat (n) @(negedge clk_in);
    endtask

    // One move along one axis: advance by the step, pinning to the wall and reversing when it is reached.
    function automatic void move_axis(inout int pos, inout int dir, input int lim, input int st,
                                      output bit flipped);
        flipped = 1'b0;
        if (dir > 0) begin
            if (pos + st >= lim) begin pos = lim; dir = -1; flipped = 1'b1; end
            else pos = pos + st;
        end else begin
            if (pos <= st) begin pos = 0; dir = 1; flipped = 1'b1; end
            else pos = pos - st;
        end
    endfunction

    // Reference model: a step happens two edges after the first high sample of a rising tick.
    always @(posedge clk_in) begin : model
        bit step, fx, fy;
        if (act_mv[0]) strobes_a++;
        cyc++;
        if (rst) begin
            hist[cyc] = 1'b1; hist[cyc-1] = 1'b1; hist[cyc-2] = 1'b1;
            model_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_x[i] = p_x0[i]; m_y[i] = p_y0[i]; m_dx[i] = 1; m_dy[i] = 1;
                m_mv[i] = 1'b0; m_bo[i] = 1'b0; m_co[i] = 1'b0;
            end
        end else begin
            hist[cyc] = tick;
            step = model_valid && hist[cyc-2] && !hist[cyc-3] && run;
            for (int i = 0; i < 4; i++) begin
                fx = 1'b0; fy = 1'b0;
                if (step) begin
                    move_axis(m_x[i], m_dx[i], XMAX, p_st[i], fx);
                    move_axis(m_y[i], m_dy[i], YMAX, p_st[i], fy);
                end
                m_mv[i] = step; m_bo[i] = fx | fy; m_co[i] = fx & fy;
            end
        end
    end

    always @(negedge clk_in) begin
        if (model_valid) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("%s x_pos", nm[i]), int'(act_x[i]), m_x[i]);
                checkOutput($sformatf("%s y_pos", nm[i]), int'(act_y[i]), m_y[i]);
                checkOutput($sformatf("%s dir_x", nm[i]), int'(act_dx[i]), int'(m_dx[i] > 0));
                checkOutput($sformatf("%s dir_y", nm[i]), int'(act_dy[i]), int'(m_dy[i] > 0));
                checkOutput($sformatf("%s move_strobe", nm[i]), int'(act_mv[i]), int'(m_mv[i]));
                checkOutput($sformatf("%s bounce", nm[i]), int'(act_bo[i]), int'(m_bo[i]));
                checkOutput($sformatf("%s corner", nm[i]), int'(act_co[i]), int'(m_co[i]));
            end
        end
    end

    initial begin
        int base;
        tick = 1'b1; run = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk_in);

        applyStimulus(1, 1, 0, 20);
        checkOutput("lit A reset x", int'(act_x[0]), 0);
        checkOutput("lit A reset y", int'(act_y[0]), 0);
        checkOutput("lit A reset dir_x", int'(act_dx[0]), 1);
        checkOutput("lit A reset dir_y", int'(act_dy[0]), 1);
        checkOutput("lit B reset x", int'(act_x[1]), 622);
        checkOutput("lit no strobe after reset", strobes_a, 0);

        applyStimulus(0, 1, 0, 3);
        base = strobes_a;
        tick = 1'b1;
        @(negedge clk_in);
        checkOutput("lit strobe at k", int'(act_mv[0]), 0);
        @(negedge clk_in);
        checkOutput("lit strobe at k+1", int'(act_mv[0]), 0);
        @(negedge clk_in);
        checkOutput("lit strobe at k+2", int'(act_mv[0]), 1);
        checkOutput("lit A step1 x", int'(act_x[0]), 1);
        checkOutput("lit A step1 y", int'(act_y[0]), 1);
        checkOutput("lit B step1 x", int'(act_x[1]), 623);
        checkOutput("lit B step1 bounce", int'(act_bo[1]), 0);
        checkOutput("lit C step1 x", int'(act_x[2]), 624);
        checkOutput("lit C step1 y", int'(act_y[2]), 464);
        checkOutput("lit C step1 bounce", int'(act_bo[2]), 1);
        checkOutput("lit C step1 corner", int'(act_co[2]), 1);
        checkOutput("lit C step1 dir_x", int'(act_dx[2]), 0);
        checkOutput("lit C step1 dir_y", int'(act_dy[2]), 0);
        applyStimulus(1, 1, 0, 7);
        applyStimulus(0, 1, 0, 3);
        checkOutput("lit one strobe per long tick", strobes_a - base, 1);

        tick = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("lit B step2 x", int'(act_x[1]), 624);
        checkOutput("lit B step2 dir_x", int'(act_dx[1]), 0);
        checkOutput("lit B step2 bounce", int'(act_bo[1]), 1);
        checkOutput("lit B step2 corner", int'(act_co[1]), 0);
        checkOutput("lit C step2 x", int'(act_x[2]), 623);
        checkOutput("lit C step2 y", int'(act_y[2]), 463);
        applyStimulus(1, 1, 0, 3);
        applyStimulus(0, 1, 0, 3);

        tick = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("lit B step3 x", int'(act_x[1]), 623);
        checkOutput("lit B step3 y", int'(act_y[1]), 103);
        checkOutput("lit B step3 bounce", int'(act_bo[1]), 0);
        applyStimulus(1, 1, 0, 3);
        applyStimulus(0, 1, 0, 3);

        // Frozen motion, then enabling run while the tick is already high.
        base = strobes_a;
        repeat (5) begin
            applyStimulus(1, 0, 0, 3);
            applyStimulus(0, 0, 0, 3);
        end
        applyStimulus(1, 0, 0, 4);
        applyStimulus(1, 1, 0, 6);
        checkOutput("lit no strobe while frozen", strobes_a - base, 0);
        checkOutput("lit A frozen x", int'(act_x[0]), 3);
        checkOutput("lit A frozen y", int'(act_y[0]), 3);
        applyStimulus(0, 1, 0, 3);
        tick = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("lit step after run", int'(act_mv[0]), 1);
        checkOutput("lit A x after run", int'(act_x[0]), 4);
        applyStimulus(1, 1, 0, 2);
        applyStimulus(0, 1, 0, 3);

        // Reset lands one edge after the tick was first sampled high.
        base = strobes_a;
        tick = 1'b1;
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        applyStimulus(1, 1, 0, 6);
        checkOutput("lit no strobe after abort", strobes_a - base, 0);
        checkOutput("lit A abort x", int'(act_x[0]), 0);
        checkOutput("lit A abort y", int'(act_y[0]), 0);
        checkOutput("lit B abort x", int'(act_x[1]), 622);
        applyStimulus(0, 1, 0, 3);
        tick = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("lit fresh edge strobe", int'(act_mv[0]), 1);
        checkOutput("lit fresh edge A x", int'(act_x[0]), 1);
        applyStimulus(1, 1, 0, 2);

        for (int n = 0; n < 2000 && cyc < HIST_N - 100; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
                          $urandom_range(0, 799) == 0, $urandom_range(1, 6));
        end
        applyStimulus(0, 1, 0, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
